// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module : game_pkg
// Shared damage-controller state encoding, default tuning constants and a
// counter-width helper.
// Rev    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        KNOCKBACK = 2'd1,
        INVULN    = 2'd2,
        DEAD      = 2'd3
    } dmg_state_e;

    localparam int DEF_MAX_HEALTH       = 3;
    localparam int DEF_KNOCKBACK_FRAMES = 8;
    localparam int DEF_INVULN_FRAMES    = 60;
    localparam int DEF_KNOCK_SPEED      = 2;
    localparam int DEF_STOMP_MARGIN     = 4;

    // Wide enough to hold the larger of the two frame counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aabb_overlap.sv
`default_nettype none
// ============================================================================
// Module : aabb_overlap
// Combinational inclusive axis-aligned box overlap test, wrap-free 11-bit sums.
// Rev    : 1.0 - initial release
// ============================================================================
module aabb_overlap (
    input  logic [9:0] a_x_i,
    input  logic [9:0] a_y_i,
    input  logic [9:0] a_w_i,
    input  logic [9:0] a_h_i,
    input  logic [9:0] b_x_i,
    input  logic [9:0] b_y_i,
    input  logic [9:0] b_w_i,
    input  logic [9:0] b_h_i,
    output logic       overlap_o
);

    logic [10:0] w_a_right;
    logic [10:0] w_a_bottom;
    logic [10:0] w_b_right;
    logic [10:0] w_b_bottom;

    assign w_a_right  = {1'b0, a_x_i} + {1'b0, a_w_i};
    assign w_a_bottom = {1'b0, a_y_i} + {1'b0, a_h_i};
    assign w_b_right  = {1'b0, b_x_i} + {1'b0, b_w_i};
    assign w_b_bottom = {1'b0, b_y_i} + {1'b0, b_h_i};

    assign overlap_o = ({1'b0, a_x_i} <= w_b_right)  &&
                       ({1'b0, b_x_i} <= w_a_right)  &&
                       ({1'b0, a_y_i} <= w_b_bottom) &&
                       ({1'b0, b_y_i} <= w_a_bottom);

endmodule
`default_nettype wire

// File: rtl/player_damage_ctrl.sv
`default_nettype none
// ============================================================================
// Module : player_damage_ctrl
// Player hit / knockback / invulnerability / death sequencer against one enemy.
// Optional macro SLIME_STOMP_EN: landing on the enemy's top band is harmless
// and raises stomp_pulse instead of a hit.
// Rev    : 1.0 - initial release
// ============================================================================
module player_damage_ctrl
    import game_pkg::*;
#(
    parameter int MAX_HEALTH       = DEF_MAX_HEALTH,
    parameter int KNOCKBACK_FRAMES = DEF_KNOCKBACK_FRAMES,
    parameter int INVULN_FRAMES    = DEF_INVULN_FRAMES,
    parameter int KNOCK_SPEED      = DEF_KNOCK_SPEED,
    parameter int STOMP_MARGIN     = DEF_STOMP_MARGIN
) (
    input  logic        sim_clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic [19:0] playerPos,
    input  logic [9:0]  player_width,
    input  logic [9:0]  player_height,
    input  logic [9:0]  enemy_x,
    input  logic [9:0]  enemy_y,
    input  logic [9:0]  enemy_width,
    input  logic [9:0]  enemy_height,
    output logic [2:0]  health,
    output logic        hit_pulse,
    output logic        knockback_active,
    output logic [9:0]  knockback_dx,
    output logic        invulnerable,
    output logic        player_dead,
    output logic        stomp_pulse
);

    localparam int         CNT_W    = cnt_width(KNOCKBACK_FRAMES, INVULN_FRAMES);
    localparam logic [9:0] DX_RIGHT = 10'(KNOCK_SPEED);
    localparam logic [9:0] DX_LEFT  = 10'(0 - KNOCK_SPEED);

    logic [9:0]  w_px;
    logic [9:0]  w_py;
    logic        w_overlap;
    logic        w_stomp;
    logic [10:0] w_feet;
    logic [10:0] w_band;

    dmg_state_e       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       health_q, health_d;
    logic             dir_right_q, dir_right_d;
    logic             hit_q,    hit_d;
    logic             kb_q,     kb_d;
    logic             inv_q,    inv_d;
    logic             dead_q,   dead_d;
    logic [9:0]       dx_q,     dx_d;

    assign w_px = playerPos[19:10];
    assign w_py = playerPos[9:0];

    aabb_overlap u_overlap (
        .a_x_i     (w_px),
        .a_y_i     (w_py),
        .a_w_i     (player_width),
        .a_h_i     (player_height),
        .b_x_i     (enemy_x),
        .b_y_i     (enemy_y),
        .b_w_i     (enemy_width),
        .b_h_i     (enemy_height),
        .overlap_o (w_overlap)
    );

    // Player's feet sit within the enemy's top band.
    assign w_feet = {1'b0, w_py} + {1'b0, player_height};
    assign w_band = {1'b0, enemy_y} + 11'(STOMP_MARGIN);

`ifdef SLIME_STOMP_EN
    logic stomp_q, stomp_d;
    assign w_stomp = (w_feet <= w_band);
`else
    logic w_unused_stomp;
    assign w_stomp        = 1'b0;
    assign w_unused_stomp = ^{w_feet, w_band};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        health_d    = health_q;
        dir_right_d = dir_right_q;
        hit_d       = 1'b0;
`ifdef SLIME_STOMP_EN
        stomp_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (frame_tick && w_overlap) begin
                    if (w_stomp) begin
`ifdef SLIME_STOMP_EN
                        stomp_d = 1'b1;
`endif
                    end else begin
                        health_d    = (health_q != 3'd0) ? health_q - 3'd1 : 3'd0;
                        hit_d       = 1'b1;
                        dir_right_d = (w_px >= enemy_x);
                        if (health_d == 3'd0) begin
                            state_d = DEAD;
                            cnt_d   = '0;
                        end else begin
                            state_d = KNOCKBACK;
                            cnt_d   = CNT_W'(KNOCKBACK_FRAMES);
                        end
                    end
                end
            end
            KNOCKBACK: begin
                if (frame_tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = INVULN;
                        cnt_d   = CNT_W'(INVULN_FRAMES);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            INVULN: begin
                if (frame_tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d  = DEAD;
                health_d = 3'd0;
                cnt_d    = '0;
            end
        endcase

        // Status flags are decoded from the next state so they land on the same edge.
        kb_d   = (state_d == KNOCKBACK);
        inv_d  = (state_d == KNOCKBACK) || (state_d == INVULN);
        dead_d = (state_d == DEAD);
        dx_d   = kb_d ? (dir_right_d ? DX_RIGHT : DX_LEFT) : 10'd0;
    end

    always_ff @(posedge sim_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            health_q    <= 3'(MAX_HEALTH);
            dir_right_q <= 1'b0;
            hit_q       <= 1'b0;
            kb_q        <= 1'b0;
            inv_q       <= 1'b0;
            dead_q      <= 1'b0;
            dx_q        <= 10'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            health_q    <= health_d;
            dir_right_q <= dir_right_d;
            hit_q       <= hit_d;
            kb_q        <= kb_d;
            inv_q       <= inv_d;
            dead_q      <= dead_d;
            dx_q        <= dx_d;
        end
    end

`ifdef SLIME_STOMP_EN
    always_ff @(posedge sim_clk or negedge reset_n) begin
        if (!reset_n) begin
            stomp_q <= 1'b0;
        end else begin
            stomp_q <= stomp_d;
        end
    end
    assign stomp_pulse = stomp_q;
`else
    assign stomp_pulse = 1'b0;
`endif

    assign health           = health_q;
    assign hit_pulse        = hit_q;
    assign knockback_active = kb_q;
    assign knockback_dx     = dx_q;
    assign invulnerable     = inv_q;
    assign player_dead      = dead_q;

endmodule
`default_nettype wire

// File: tb/tb_player_damage_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_player_damage_ctrl
// Directed and randomized bench for player_damage_ctrl against a frame-budget
// reference model. Honours SLIME_STOMP_EN when defined.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_player_damage_ctrl;

    localparam int MAXH = 3;
    localparam int KB   = 8;
    localparam int INV  = 60;
    localparam int KSP  = 2;
    localparam int SM   = 4;

    logic        sim_clk;
    logic        reset_n;
    logic        frame_tick;
    logic [19:0] playerPos;
    logic [9:0]  player_width, player_height;
    logic [9:0]  enemy_x, enemy_y, enemy_width, enemy_height;
    logic [2:0]  health;
    logic        hit_pulse, knockback_active, invulnerable, player_dead, stomp_pulse;
    logic [9:0]  knockback_dx;

    int vectors;
    int miscompares;

    // Model: remaining protected frames (knockback + invuln) rather than states.
    int m_health;
    int m_recov;
    bit m_dead;
    bit m_right;
    bit m_hit;
    bit m_stomp;

    player_damage_ctrl #(
        .MAX_HEALTH       (MAXH),
        .KNOCKBACK_FRAMES (KB),
        .INVULN_FRAMES    (INV),
        .KNOCK_SPEED      (KSP),
        .STOMP_MARGIN     (SM)
    ) dut (
        .sim_clk          (sim_clk),
        .reset_n          (reset_n),
        .frame_tick       (frame_tick),
        .playerPos        (playerPos),
        .player_width     (player_width),
        .player_height    (player_height),
        .enemy_x          (enemy_x),
        .enemy_y          (enemy_y),
        .enemy_width      (enemy_width),
        .enemy_height     (enemy_height),
        .health           (health),
        .hit_pulse        (hit_pulse),
        .knockback_active (knockback_active),
        .knockback_dx     (knockback_dx),
        .invulnerable     (invulnerable),
        .player_dead      (player_dead),
        .stomp_pulse      (stomp_pulse)
    );

    initial begin
        sim_clk = 1'b0;
        forever #5 sim_clk = ~sim_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_overlap();
        int px, py, pw, ph, ex, ey, ew, eh;
        px = int'(playerPos[19:10]); py = int'(playerPos[9:0]);
        pw = int'(player_width);     ph = int'(player_height);
        ex = int'(enemy_x);          ey = int'(enemy_y);
        ew = int'(enemy_width);      eh = int'(enemy_height);
        return (px <= ex + ew) && (ex <= px + pw) && (py <= ey + eh) && (ey <= py + ph);
    endfunction

    function automatic bit model_stomp();
`ifdef SLIME_STOMP_EN
        return (int'(playerPos[9:0]) + int'(player_height)) <= (int'(enemy_y) + SM);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_health = MAXH; m_recov = 0; m_dead = 0;
        m_right = 0; m_hit = 0; m_stomp = 0;
    endtask

    task automatic check_all(input string tag);
        bit          e_kb;
        bit          e_inv;
        logic [9:0]  e_dx;
        e_kb  = !m_dead && (m_recov > INV);
        e_inv = !m_dead && (m_recov > 0);
        e_dx  = e_kb ? (m_right ? 10'(KSP) : 10'(1024 - KSP)) : 10'd0;
        chk({tag, ".health"}, 32'(health),           32'(m_dead ? 0 : m_health));
        chk({tag, ".hit"},    32'(hit_pulse),        32'(m_hit));
        chk({tag, ".kb"},     32'(knockback_active), 32'(e_kb));
        chk({tag, ".dx"},     32'(knockback_dx),     32'(e_dx));
        chk({tag, ".inv"},    32'(invulnerable),     32'(e_inv));
        chk({tag, ".dead"},   32'(player_dead),      32'(m_dead));
        chk({tag, ".stomp"},  32'(stomp_pulse),      32'(m_stomp));
    endtask

    task automatic step(input bit tick, input string tag);
        frame_tick = tick;
        m_hit = 0; m_stomp = 0;
        if (tick && !m_dead) begin
            if (m_recov > 0) begin
                m_recov--;
            end else if (model_overlap()) begin
                if (model_stomp()) begin
                    m_stomp = 1;
                end else begin
                    m_health = (m_health > 0) ? m_health - 1 : 0;
                    m_hit    = 1;
                    m_right  = (playerPos[19:10] >= enemy_x);
                    if (m_health == 0) m_dead = 1;
                    else               m_recov = KB + INV;
                end
            end
        end
        @(posedge sim_clk);
        #1;
        frame_tick = 1'b0;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed well away from the clock edge.
    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge sim_clk);
        #1;
        check_all({tag, "_hold"});
        reset_n = 1'b1;
    endtask

    task automatic set_pos(input int px, input int py, input int pw, input int ph,
                           input int ex, input int ey, input int ew, input int eh);
        playerPos     = {10'(px), 10'(py)};
        player_width  = 10'(pw);
        player_height = 10'(ph);
        enemy_x       = 10'(ex);
        enemy_y       = 10'(ey);
        enemy_width   = 10'(ew);
        enemy_height  = 10'(eh);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset_n = 1'b0; frame_tick = 1'b0;
        set_pos(0, 0, 0, 0, 500, 500, 0, 0);
        #12;
        model_reset();
        check_all("por");
        chk("por_health_const", 32'(health), 32'd3);
        reset_n = 1'b1;
        @(posedge sim_clk); #1;

        set_pos(100, 200, 16, 16, 110, 200, 20, 16);
        for (int i = 0; i < 100; i++) step(1'b0, "notick");
        chk("notick_health_const", 32'(health), 32'd3);

        step(1'b1, "first_hit");
        chk("first_hit_pulse", 32'(hit_pulse), 32'd1);
        chk("first_hit_health", 32'(health), 32'd2);
        chk("first_hit_dx", 32'(knockback_dx), 32'h3FE);
        step(1'b0, "first_hit_after");

        for (int i = 0; i < KB + INV; i++) begin
            step(1'b1, "recover_tick");
            step(1'b0, "recover_gap");
            if (i == KB - 2) chk("kb_last", 32'(knockback_active), 32'd1);
            if (i == KB - 1) chk("inv_first", 32'(invulnerable), 32'd1);
        end
        chk("back_idle_inv", 32'(invulnerable), 32'd0);
        chk("back_idle_health", 32'(health), 32'd2);

        step(1'b1, "second_hit");
        for (int i = 0; i < 3; i++) step(1'b1, "kb_run");
        chk("mid_kb", 32'(knockback_active), 32'd1);
        do_reset("rst_mid_kb");
        chk("rst_health_const", 32'(health), 32'd3);
        step(1'b1, "post_rst_hit");
        chk("post_rst_hit_const", 32'(hit_pulse), 32'd1);

        do_reset("rst_stomp");
        set_pos(100, 186, 16, 16, 110, 200, 20, 16);
        step(1'b1, "stomp");
`ifdef SLIME_STOMP_EN
        chk("stomp_pulse_const", 32'(stomp_pulse), 32'd1);
        chk("stomp_health_const", 32'(health), 32'd3);
`else
        chk("stomp_as_hit_const", 32'(hit_pulse), 32'd1);
        chk("stomp_as_hit_health", 32'(health), 32'd2);
`endif

        do_reset("rst_death");
        for (int h = 0; h < 3; h++) begin
            set_pos(130, 200, 16, 16, 110, 200, 20, 16);
            step(1'b1, "death_hit");
            set_pos(130, 200, 16, 16, 600, 600, 20, 16);
            for (int i = 0; i < KB + INV + 2; i++) step(1'b1, "death_sep");
        end
        chk("dead_flag", 32'(player_dead), 32'd1);
        chk("dead_health", 32'(health), 32'd0);
        set_pos(130, 200, 16, 16, 110, 200, 20, 16);
        for (int i = 0; i < 5; i++) step(1'b1, "dead_overlap");
        do_reset("rst_from_dead");

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0)
                set_pos(int'($urandom_range(1000, 1023)), int'($urandom_range(1000, 1023)),
                        int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                        int'($urandom_range(990, 1023)), int'($urandom_range(990, 1023)),
                        int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
            else
                set_pos(int'($urandom_range(90, 140)), int'($urandom_range(170, 220)),
                        int'($urandom_range(8, 24)), int'($urandom_range(8, 24)),
                        int'($urandom_range(100, 140)), int'($urandom_range(190, 220)),
                        int'($urandom_range(8, 24)), int'($urandom_range(8, 24)));
            if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
            else step(($urandom_range(0, 2) == 0), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
